// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter in front of a single-port synchronous SRAM. The CPU has fixed
// priority, a DMA starvation guard overrides it, and read data is routed back one cycle later.
//
// rd_owner state | meaning
// ---------------+-----------------------------------------------
// RD_NONE        | no read in flight, both rdata buses are 0
// RD_CPU         | last cycle issued a CPU read; sram_DO goes to the CPU
// RD_DMA         | last cycle issued a DMA read; sram_DO goes to the DMA
module sram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic [DATA_W-1:0] sram_DI,
    output logic              sram_EN,
    output logic              sram_WE,
    input  logic [DATA_W-1:0] sram_DO,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DMA} rd_state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rd_state_t  rd_owner;
    rd_state_t  rd_next;
    logic [3:0] starve;
    logic       starve_hit;

    assign starve_hit = (starve == STARVE_LIM);

    // Everything is gated by reset so requests are ignored and outputs read 0 while it is held.
    always_comb begin
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        sram_EN    = 1'b0;
        sram_WE    = 1'b0;
        sram_ADDR  = '0;
        sram_DI    = '0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        rd_next    = RD_NONE;
        if (!reset) begin
            dma_gnt = dma_req & (~cpu_req | starve_hit);
            cpu_gnt = cpu_req & ~dma_gnt;
            sram_EN = cpu_gnt | dma_gnt;
            if (cpu_gnt) begin
                sram_WE   = cpu_we;
                sram_ADDR = cpu_addr;
                sram_DI   = cpu_wdata;
                rd_next   = cpu_we ? RD_NONE : RD_CPU;
            end else if (dma_gnt) begin
                sram_WE   = dma_we;
                sram_ADDR = dma_addr;
                sram_DI   = dma_wdata;
                rd_next   = dma_we ? RD_NONE : RD_DMA;
            end
            case (rd_owner)
                RD_CPU: begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = sram_DO;
                end
                RD_DMA: begin
                    dma_rvalid = 1'b1;
                    dma_rdata  = sram_DO;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner     <= RD_NONE;
            starve       <= 4'd0;
            conflict_cnt <= 16'd0;
        end else begin
            rd_owner <= rd_next;
            if (dma_req && !dma_gnt) begin
                if (!starve_hit) starve <= starve + 4'd1;
            end else begin
                starve <= 4'd0;
            end
            if (cpu_req && dma_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM behavioural model, directed vector table, contention and
// reset sequences, randomized traffic against a transaction-level reference, counter saturation.
module tb_sram_arbiter;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI;
    logic        sram_EN, sram_WE;
    logic [31:0] sram_DO = 32'd0;
    logic [15:0] conflict_cnt;

    sram_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
        .sram_DO(sram_DO), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM: read data appears the cycle after an EN & !WE cycle.
    bit [31:0] mem [65536];
    always @(posedge clk) begin
        if (sram_EN) begin
            if (sram_WE) mem[sram_ADDR] <= sram_DI;
            else         sram_DO <= mem[sram_ADDR];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who wins, the one read awaiting return, counters.
    logic [31:0] ref_mem [logic [15:0]];
    int          denied;
    int          conflicts;
    int          pend_who;     // 0 none, 1 cpu, 2 dma
    logic [31:0] pend_data;
    logic        e_cpu, e_dma;
    bit          hold_cpu, hold_dma;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    task automatic model_check();
        logic        e_we;
        logic [15:0] e_addr;
        logic [31:0] e_di;
        e_dma = !reset && dma_req && (!cpu_req || denied == STARVE_MAX);
        e_cpu = !reset && cpu_req && !e_dma;
        e_we   = e_cpu ? cpu_we    : e_dma ? dma_we    : 1'b0;
        e_addr = e_cpu ? cpu_addr  : e_dma ? dma_addr  : 16'd0;
        e_di   = e_cpu ? cpu_wdata : e_dma ? dma_wdata : 32'd0;
        chk("cpu_gnt", cpu_gnt, e_cpu);
        chk("dma_gnt", dma_gnt, e_dma);
        chk("gnt_onehot", cpu_gnt & dma_gnt, 0);
        chk("sram_EN", sram_EN, e_cpu | e_dma);
        chk("sram_WE", sram_WE, e_we);
        chk("sram_ADDR", sram_ADDR, e_addr);
        chk("sram_DI", sram_DI, e_di);
        chk("cpu_rvalid", cpu_rvalid, !reset && pend_who == 1);
        chk("cpu_rdata", cpu_rdata, (!reset && pend_who == 1) ? pend_data : 32'd0);
        chk("dma_rvalid", dma_rvalid, !reset && pend_who == 2);
        chk("dma_rdata", dma_rdata, (!reset && pend_who == 2) ? pend_data : 32'd0);
        chk("conflict_cnt", conflict_cnt, conflicts);
    endtask

    task automatic model_update();
        if (reset) begin
            denied = 0; conflicts = 0; pend_who = 0;
        end else begin
            if (cpu_req && dma_req && conflicts < 65535) conflicts++;
            if (dma_req && !e_dma) denied = (denied < STARVE_MAX) ? denied + 1 : denied;
            else                   denied = 0;
            pend_who = 0;
            if (e_cpu) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else begin pend_who = 1; pend_data = ref_rd(cpu_addr); end
            end else if (e_dma) begin
                if (dma_we) ref_mem[dma_addr] = dma_wdata;
                else begin pend_who = 2; pend_data = ref_rd(dma_addr); end
            end
        end
        hold_cpu = cpu_req && !e_cpu;
        hold_dma = dma_req && !e_dma;
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
    endtask

    // n cycles of continuous dual write requests; DMA must win every (STARVE_MAX+1)th cycle.
    task automatic contention(input int n);
        for (int i = 0; i < n; i++) begin
            set_cpu(1, 1, 16'h0020 + 16'(i), 32'hC000_0000 + i);
            set_dma(1, 1, 16'h0040, 32'hD000_0000 + i);
            at_neg();
            chk("contend_dma_gnt", dma_gnt, (i % (STARVE_MAX + 1)) == STARVE_MAX);
            chk("contend_cpu_gnt", cpu_gnt, (i % (STARVE_MAX + 1)) != STARVE_MAX);
            at_pos();
        end
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
    endtask

    typedef struct {
        logic        cr, cw;
        logic [15:0] ca;
        logic [31:0] cd;
        logic        dr, dw;
        logic [15:0] da;
        logic [31:0] dd;
        logic        e_cg, e_dg, e_we;
        logic [15:0] e_addr;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    function automatic vec_t mk(input logic cr, cw, input logic [15:0] ca, input logic [31:0] cd,
                                input logic dr, dw, input logic [15:0] da, input logic [31:0] dd,
                                input logic cg, dg, we, input logic [15:0] ea,
                                input logic crv, input logic [31:0] crd,
                                input logic drv, input logic [31:0] drd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.e_cg = cg; v.e_dg = dg; v.e_we = we; v.e_addr = ea;
        v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(1,1,16'h0010,32'h1234ABCD, 0,0,0,0,                 1,0,1,16'h0010, 0,0,            0,0);
        tbl[1]  = mk(1,0,16'h0010,0,           0,0,0,0,                 1,0,0,16'h0010, 0,0,            0,0);
        tbl[2]  = mk(0,0,0,0,                  0,0,0,0,                 0,0,0,16'h0000, 1,32'h1234ABCD, 0,0);
        tbl[3]  = mk(1,1,16'h0005,32'hAA,      0,0,0,0,                 1,0,1,16'h0005, 0,0,            0,0);
        tbl[4]  = mk(0,0,0,0,                  1,1,16'h0006,32'hBB,     0,1,1,16'h0006, 0,0,            0,0);
        tbl[5]  = mk(1,0,16'h0005,0,           0,0,0,0,                 1,0,0,16'h0005, 0,0,            0,0);
        tbl[6]  = mk(0,0,0,0,                  1,0,16'h0006,0,          0,1,0,16'h0006, 1,32'hAA,       0,0);
        tbl[7]  = mk(0,0,0,0,                  0,0,0,0,                 0,0,0,16'h0000, 0,0,            1,32'hBB);
        tbl[8]  = mk(0,0,0,0,                  1,1,16'h0100,32'hDEADBEEF, 0,1,1,16'h0100, 0,0,          0,0);
        tbl[9]  = mk(1,0,16'h0100,0,           0,0,0,0,                 1,0,0,16'h0100, 0,0,            0,0);
        tbl[10] = mk(0,0,0,0,                  0,0,0,0,                 0,0,0,16'h0000, 1,32'hDEADBEEF, 0,0);

        denied = 0; conflicts = 0; pend_who = 0; pend_data = 0;
        hold_cpu = 0; hold_dma = 0;

        // Reset with both requests asserted: they must be ignored.
        reset = 1;
        set_cpu(1, 0, 16'h0010, 32'h1);
        set_dma(1, 0, 16'h0011, 32'h2);
        repeat (2) begin at_neg(); at_pos(); end
        reset = 0;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        at_neg();
        chk("reset_conflict_cnt", conflict_cnt, 0);
        chk("reset_rvalid", cpu_rvalid | dma_rvalid, 0);
        at_pos();

        for (int i = 0; i < 11; i++) begin
            set_cpu(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd);
            set_dma(tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            at_neg();
            chk($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, tbl[i].e_cg);
            chk($sformatf("vec%0d_dma_gnt", i), dma_gnt, tbl[i].e_dg);
            chk($sformatf("vec%0d_sram_WE", i), sram_WE, tbl[i].e_we);
            chk($sformatf("vec%0d_sram_ADDR", i), sram_ADDR, tbl[i].e_addr);
            chk($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, tbl[i].e_crv);
            chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
            chk($sformatf("vec%0d_dma_rvalid", i), dma_rvalid, tbl[i].e_drv);
            chk($sformatf("vec%0d_dma_rdata", i), dma_rdata, tbl[i].e_drd);
            at_pos();
        end

        contention(10);
        at_neg();
        chk("contend_conflict_cnt", conflict_cnt, 10);
        at_pos();

        // Reset right after a granted CPU read: the return is dropped.
        set_cpu(1, 0, 16'h0010, 0);
        at_neg();
        chk("rst_read_gnt", cpu_gnt, 1);
        at_pos();
        set_cpu(0, 0, 0, 0);
        reset = 1;
        at_neg();
        chk("rst_read_rvalid", cpu_rvalid, 0);
        at_pos();
        reset = 0;
        at_neg();
        chk("post_rst_rvalid", cpu_rvalid | dma_rvalid, 0);
        chk("post_rst_conflict", conflict_cnt, 0);
        at_pos();
        contention(STARVE_MAX + 1);

        // Randomized traffic; a denied requester holds its request stable.
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (!hold_cpu)
                set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 15)), $urandom);
            if (!hold_dma)
                set_dma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 15)), $urandom);
            at_neg();
            at_pos();
        end

        // Saturation: 65536 dual-request cycles must pin the counter at 0xFFFF.
        reset = 0;
        for (int n = 0; n < 65540; n++) begin
            set_cpu(1, 1, 16'h0200, 32'h5);
            set_dma(1, 1, 16'h0201, 32'h6);
            at_neg();
            at_pos();
        end
        at_neg();
        chk("sat_conflict_cnt", conflict_cnt, 16'hFFFF);
        at_pos();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
